// File: rtl/ex_md_pkg.sv
// Shared types and decode helpers for the ex_md multiply/divide unit.
package ex_md_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_funct_e;

    function automatic logic is_div(input md_funct_e f);
        return f[2];
    endfunction

    // Plain MUL keeps only the low word, which is the same for any signedness.
    function automatic logic rs1_signed(input md_funct_e f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    function automatic logic rs2_signed(input md_funct_e f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/ex_md_step.sv
// One combinational iteration: conditional add (multiply) or trial subtract (divide).
module ex_md_step #(
    parameter int XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN:0]   i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opd,
    output logic [XLEN:0]   o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   w_sum;
    logic [XLEN+1:0] w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic            w_fits;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    always_comb begin
        w_sum    = i_hi + {1'b0, i_opd};
        w_sum    = i_lo[0] ? w_sum : i_hi;
        w_rem_sh = {i_hi, i_lo[XLEN-1]};
        w_fits   = (w_rem_sh >= {2'b00, i_opd});
        w_trial  = w_rem_sh[XLEN:0] - {1'b0, i_opd};
        if (i_is_div) begin
            o_hi = w_fits ? w_trial : w_rem_sh[XLEN:0];
            o_lo = {i_lo[XLEN-2:0], w_fits};
        end else begin
            o_hi = {1'b0, w_sum[XLEN:1]};
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_md.sv
// Iterative RV M-extension execute unit: shift-add multiply, restoring divide,
// STEP_BITS result bits per cycle, flushable at any point.
module ex_md
    import ex_md_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      md_funct,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int N  = XLEN / STEP_BITS;
    localparam int CW = $clog2(N + 1);

    md_state_e       r_state, w_state_nxt;
    md_funct_e       r_funct, w_funct;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   r_hi;
    logic [XLEN-1:0] r_lo, r_opd, r_result;
    logic            r_neg;

    logic            w_accept, w_s1, w_s2, w_neg, w_div0, w_ovf, w_fast;
    logic [XLEN-1:0] w_mag1, w_mag2, w_fast_res, w_quo, w_rem, w_fix;
    logic [2*XLEN-1:0] w_prod;

    logic [XLEN:0]   w_hi [STEP_BITS+1];
    logic [XLEN-1:0] w_lo [STEP_BITS+1];

    assign w_hi[0] = r_hi;
    assign w_lo[0] = r_lo;

    for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
        ex_md_step #(.XLEN(XLEN)) u_step (
            .i_is_div (is_div(r_funct)),
            .i_hi     (w_hi[g]),
            .i_lo     (w_lo[g]),
            .i_opd    (r_opd),
            .o_hi     (w_hi[g+1]),
            .o_lo     (w_lo[g+1])
        );
    end

    // Operand conditioning and the skip-CALC special cases, valid in the accept cycle.
    always_comb begin
        w_funct    = md_funct_e'(md_funct);
        w_s1       = rs1_signed(w_funct) & rs1_data[XLEN-1];
        w_s2       = rs2_signed(w_funct) & rs2_data[XLEN-1];
        w_mag1     = w_s1 ? -rs1_data : rs1_data;
        w_mag2     = w_s2 ? -rs2_data : rs2_data;
        w_neg      = (is_div(w_funct) && w_funct[1]) ? w_s1 : (w_s1 ^ w_s2);
        w_div0     = is_div(w_funct) && (rs2_data == '0);
        w_ovf      = ((w_funct == MD_DIV) || (w_funct == MD_REM)) &&
                     (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        w_fast     = w_div0 || w_ovf;
        w_fast_res = w_div0 ? (w_funct[1] ? rs1_data : '1)
                            : (w_funct[1] ? '0 : rs1_data);
    end

    // Sign fix-up applied to the final iteration's outputs on entry to DONE.
    always_comb begin
        w_prod = {w_hi[STEP_BITS][XLEN-1:0], w_lo[STEP_BITS]};
        w_prod = r_neg ? -w_prod : w_prod;
        w_quo  = r_neg ? -w_lo[STEP_BITS] : w_lo[STEP_BITS];
        w_rem  = r_neg ? -w_hi[STEP_BITS][XLEN-1:0] : w_hi[STEP_BITS][XLEN-1:0];
        if (!is_div(r_funct))
            w_fix = (r_funct == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        else
            w_fix = r_funct[1] ? w_rem : w_quo;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            MD_IDLE: if (in_valid) begin
                w_accept    = 1'b1;
                w_state_nxt = w_fast ? MD_DONE : MD_CALC;
            end
            MD_CALC: if (r_cnt == CW'(1)) w_state_nxt = MD_DONE;
            MD_DONE: if (out_ready) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = MD_IDLE;
            w_accept    = 1'b0;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct  <= MD_MUL;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_funct <= w_funct;
            r_cnt   <= CW'(N);
            r_hi    <= '0;
            r_lo    <= is_div(w_funct) ? w_mag1 : w_mag2;
            r_opd   <= is_div(w_funct) ? w_mag2 : w_mag1;
            r_neg   <= w_neg;
            if (w_fast) r_result <= w_fast_res;
        end else if (r_state == MD_CALC && !flush) begin
            r_cnt <= r_cnt - CW'(1);
            r_hi  <= w_hi[STEP_BITS];
            r_lo  <= w_lo[STEP_BITS];
            if (r_cnt == CW'(1)) r_result <= w_fix;
        end
    end

    assign in_ready  = (r_state == MD_IDLE);
    assign out_valid = (r_state == MD_DONE);
    assign busy      = (r_state != MD_IDLE);
    assign result    = r_result;

endmodule

// File: tb/tb_ex_md.sv
// Runs two ex_md instances (STEP_BITS 1 and 4) side by side against an arithmetic reference.
module tb_ex_md;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  md_funct;
    logic [31:0] rs1_data, rs2_data;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [31:0] a_result;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [31:0] b_result;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_md #(.XLEN(32), .STEP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .md_funct(md_funct), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .result(a_result), .busy(a_busy)
    );

    ex_md #(.XLEN(32), .STEP_BITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .md_funct(md_funct), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .result(b_result), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0];  end
            3'd1: begin p = sa * sb;                 return p[63:32]; end
            3'd2: begin p = sa * ub;                 return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after a rising edge; leaves the bench #1 after a rising edge with both units IDLE.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
        int  cyc, lat1, lat4, exp1, exp4;
        bit  fast;
        fast = f[2] && ((b == 0) ||
               ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp1 = fast ? 1 : 33;
        exp4 = fast ? 1 : 9;
        in_valid = 1'b1; md_funct = f; rs1_data = a; rs2_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0; md_funct = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        cyc = 1; lat1 = 0; lat4 = 0;
        while (cyc <= 64) begin
            if (a_out_valid && lat1 == 0) lat1 = cyc;
            if (b_out_valid && lat4 == 0) lat4 = cyc;
            if (lat1 != 0 && lat4 != 0) break;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " lat1"}, lat1, exp1);
        check({tag, " lat4"}, lat4, exp4);
        check({tag, " res1"}, a_result, exp);
        check({tag, " res4"}, b_result, exp);
        check({tag, " in_ready_done"}, {a_in_ready, b_in_ready}, 2'b00);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_res"}, a_result, exp);
            check({tag, " hold_flags"}, {a_out_valid, a_in_ready, b_out_valid, b_in_ready}, 4'b1010);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " back_idle"}, {a_in_ready, a_out_valid, b_in_ready, b_out_valid}, 4'b1010);
    endtask

    initial begin
        int seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        md_funct = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_flags", {a_out_valid, a_busy, a_in_ready, b_out_valid, b_busy, b_in_ready}, 6'b001001);
        check("reset_res", a_result | b_result, 32'h0);

        do_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        do_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        do_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        do_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        do_op("divu",    3'd5, 32'd100,        32'd7,         32'd14,        0);
        do_op("remu",    3'd7, 32'd100,        32'd7,         32'd2,         0);
        do_op("div0",    3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF, 0);
        do_op("rem0",    3'd6, 32'd5,          32'd0,         32'd5,         0);
        do_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         0);
        do_op("mul_hold",3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);

        // Flush in cycle T+10 of a DIV while another op is offered.
        in_valid = 1'b1; md_funct = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush_busy", {a_busy, b_busy}, 2'b11);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; md_funct = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle", {a_in_ready, a_busy, a_out_valid, b_in_ready, b_busy, b_out_valid}, 6'b100100);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (a_out_valid || b_out_valid || a_busy || b_busy) seen++;
        end
        check("flush_quiet", seen, 0);
        do_op("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 0);

        // Reset in the middle of an op clears the held result.
        in_valid = 1'b1; md_funct = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_flags", {a_in_ready, a_out_valid, b_in_ready, b_out_valid}, 4'b1010);
        check("rst_mid_res", a_result | b_result, 32'h0);

        for (int n = 0; n < 120; n++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op($sformatf("rnd%0d_f%0d", n, f), f, a, b, ref_md(f, a, b), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
